// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the second-generation system controller.
// This file holds the command byte codes, the state encoding and the state-class helpers.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ADDR  = 4'd1,
    ST_WR_DATA  = 4'd2,
    ST_WR_EXEC  = 4'd3,
    ST_RD_ADDR  = 4'd4,
    ST_RD_REQ   = 4'd5,
    ST_OPA_WAIT = 4'd6,
    ST_OPA_WR   = 4'd7,
    ST_OPB_WAIT = 4'd8,
    ST_OPB_WR   = 4'd9,
    ST_FUN_WAIT = 4'd10,
    ST_ALU_EXEC = 4'd11,
    ST_TX       = 4'd12
  } state_t;

  // States that consume the next frame on enable_pulse.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_WR_ADDR) || (s == ST_WR_DATA) || (s == ST_RD_ADDR) ||
           (s == ST_OPA_WAIT) || (s == ST_OPB_WAIT) || (s == ST_FUN_WAIT);
  endfunction

  // States guarded by the inactivity timeout.
  function automatic logic is_timed_state(input state_t s);
    return is_wait_state(s) || (s == ST_RD_REQ) || (s == ST_ALU_EXEC);
  endfunction

endpackage

// File: rtl/sys_ctrl_tx_ser.sv
// Result serialiser: this module holds the read or ALU result and pushes it into the TX FIFO.
// Bytes go out LSB first, and a full FIFO stalls the push.
module sys_ctrl_tx_ser
  import sys_ctrl_pkg::*;
#(
  parameter  int D_WIDTH   = 8,
  parameter  int RES_BYTES = 2,
  localparam int ALU_O_W   = D_WIDTH * RES_BYTES,
  localparam int CNT_W     = $clog2(RES_BYTES + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               load_rd,
  input  logic               load_alu,
  input  logic [D_WIDTH-1:0] rd_data,
  input  logic [ALU_O_W-1:0] alu_data,
  input  logic               tx_active,
  input  logic               FIFO_FULL,
  output logic               WR_INC,
  output logic [D_WIDTH-1:0] WR_DATA,
  output logic               tx_done
);

  logic [ALU_O_W-1:0] result_reg, result_next;
  logic [CNT_W-1:0]   idx_reg, idx_next;
  logic [CNT_W-1:0]   nbytes_reg, nbytes_next;
  logic [D_WIDTH-1:0] res_bytes [RES_BYTES];
  logic [D_WIDTH-1:0] byte_sel;
  logic               push;

  generate
    for (genvar gi = 0; gi < RES_BYTES; gi++) begin : g_bytes
      assign res_bytes[gi] = result_reg[gi*D_WIDTH +: D_WIDTH];
    end
  endgenerate

  always_comb begin
    byte_sel = '0;
    for (int i = 0; i < RES_BYTES; i++) begin
      if (idx_reg == CNT_W'(i)) byte_sel = res_bytes[i];
    end
  end

  assign push    = tx_active && !FIFO_FULL;
  assign tx_done = push && (idx_reg == nbytes_reg - CNT_W'(1));
  assign WR_INC  = push;
  assign WR_DATA = tx_active ? byte_sel : '0;

  always_comb begin
    result_next = result_reg;
    idx_next    = idx_reg;
    nbytes_next = nbytes_reg;
    if (load_rd) begin
      result_next = ALU_O_W'(rd_data);
      nbytes_next = CNT_W'(1);
      idx_next    = '0;
    end else if (load_alu) begin
      result_next = alu_data;
      nbytes_next = CNT_W'(RES_BYTES);
      idx_next    = '0;
    end else if (tx_done) begin
      idx_next = '0;
    end else if (push) begin
      idx_next = idx_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      result_reg <= '0;
      idx_reg    <= '0;
      nbytes_reg <= '0;
    end else begin
      result_reg <= result_next;
      idx_reg    <= idx_next;
      nbytes_reg <= nbytes_next;
    end
  end

endmodule

// File: rtl/sys_ctrl_v2.sv
// UART-command system controller: this module parses frames into register, ALU and FIFO traffic.
// It also detects frame timeouts, unknown commands and overruns.
module sys_ctrl_v2
  import sys_ctrl_pkg::*;
#(
  parameter  int D_WIDTH   = 8,
  parameter  int ADDR_SIZE = 4,
  parameter  int RES_BYTES = 2,
  parameter  int OPA_ADDR  = 0,
  parameter  int OPB_ADDR  = 1,
  parameter  int TIMEOUT   = 1023,
  parameter  int TO_W      = 10,
  localparam int ALU_O_W   = D_WIDTH * RES_BYTES
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [D_WIDTH-1:0]   Sync_Frame,
  input  logic                 enable_pulse,
  input  logic [D_WIDTH-1:0]   Rd_D,
  input  logic                 Rd_D_Valid,
  output logic                 Rd_En,
  output logic                 Wr_En,
  output logic [ADDR_SIZE-1:0] Addr,
  output logic [D_WIDTH-1:0]   Wr_D,
  input  logic [ALU_O_W-1:0]   ALU_OUT,
  input  logic                 OUT_Valid,
  output logic                 ALU_En,
  output logic [3:0]           FUN,
  input  logic                 FIFO_FULL,
  output logic                 WR_INC,
  output logic [D_WIDTH-1:0]   WR_DATA,
  output logic                 Gate_En,
  output logic                 CLK_DIV_EN,
  output logic                 Busy,
  output logic                 Frame_Err
);

  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  state_t               state_reg, state_next, state_adv;
  logic [ADDR_SIZE-1:0] addr_reg;
  logic [D_WIDTH-1:0]   data_reg;
  logic [3:0]           fun_reg;
  logic                 alu_op_reg;
  logic [TO_W-1:0]      to_cnt_reg, to_cnt_next;
  logic                 err_reg, err_next;
  logic                 timeout_hit, cmd_known;
  logic                 load_rd, load_alu, tx_active, tx_done;

  assign cmd_known = (Sync_Frame == D_WIDTH'(CMD_WR))     || (Sync_Frame == D_WIDTH'(CMD_RD)) ||
                     (Sync_Frame == D_WIDTH'(CMD_ALU_OP)) || (Sync_Frame == D_WIDTH'(CMD_ALU_NOP));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_adv = state_reg;
    case (state_reg)
      ST_IDLE:
        if (enable_pulse) begin
          if      (Sync_Frame == D_WIDTH'(CMD_WR))      state_adv = ST_WR_ADDR;
          else if (Sync_Frame == D_WIDTH'(CMD_RD))      state_adv = ST_RD_ADDR;
          else if (Sync_Frame == D_WIDTH'(CMD_ALU_OP))  state_adv = ST_OPA_WAIT;
          else if (Sync_Frame == D_WIDTH'(CMD_ALU_NOP)) state_adv = ST_FUN_WAIT;
        end
      ST_WR_ADDR:  if (enable_pulse) state_adv = ST_WR_DATA;
      ST_WR_DATA:  if (enable_pulse) state_adv = ST_WR_EXEC;
      ST_WR_EXEC:  state_adv = ST_IDLE;
      ST_RD_ADDR:  if (enable_pulse) state_adv = ST_RD_REQ;
      ST_RD_REQ:   if (Rd_D_Valid) state_adv = ST_TX;
      ST_OPA_WAIT: if (enable_pulse) state_adv = ST_OPA_WR;
      ST_OPA_WR:   state_adv = ST_OPB_WAIT;
      ST_OPB_WAIT: if (enable_pulse) state_adv = ST_OPB_WR;
      ST_OPB_WR:   state_adv = ST_FUN_WAIT;
      ST_FUN_WAIT: if (enable_pulse) state_adv = ST_ALU_EXEC;
      ST_ALU_EXEC: if (OUT_Valid) state_adv = ST_TX;
      ST_TX:       if (tx_done) state_adv = ST_IDLE;
      default:     state_adv = ST_IDLE;
    endcase
    // A frame or completion arriving on the last allowed cycle beats the timeout.
    timeout_hit = (TIMEOUT != 0) && is_timed_state(state_reg) && !enable_pulse &&
                  (state_adv == state_reg) && (to_cnt_reg == TO_LAST);
    state_next  = timeout_hit ? ST_IDLE : state_adv;
  end

  always_comb begin
    to_cnt_next = to_cnt_reg + TO_W'(1);
    if ((state_next != state_reg) || enable_pulse || !is_timed_state(state_reg))
      to_cnt_next = '0;
    err_next = timeout_hit ||
               (enable_pulse && (state_reg == ST_IDLE) && !cmd_known) ||
               (enable_pulse && (state_reg != ST_IDLE) && !is_wait_state(state_reg));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr_reg   <= '0;
      data_reg   <= '0;
      fun_reg    <= '0;
      alu_op_reg <= 1'b0;
      to_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (enable_pulse) begin
        case (state_reg)
          ST_IDLE:                             if (cmd_known) alu_op_reg <= (Sync_Frame == D_WIDTH'(CMD_ALU_OP));
          ST_WR_ADDR, ST_RD_ADDR:              addr_reg <= Sync_Frame[ADDR_SIZE-1:0];
          ST_WR_DATA, ST_OPA_WAIT, ST_OPB_WAIT: data_reg <= Sync_Frame;
          ST_FUN_WAIT:                         fun_reg  <= Sync_Frame[3:0];
          default: ;
        endcase
      end
      to_cnt_reg <= to_cnt_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    Rd_En   = 1'b0;
    Wr_En   = 1'b0;
    Addr    = '0;
    Wr_D    = '0;
    ALU_En  = 1'b0;
    FUN     = '0;
    Gate_En = 1'b0;
    case (state_reg)
      ST_WR_EXEC: begin
        Wr_En = 1'b1;
        Addr  = addr_reg;
        Wr_D  = data_reg;
      end
      ST_RD_REQ: begin
        Rd_En = 1'b1;
        Addr  = addr_reg;
      end
      ST_OPA_WR: begin
        Wr_En = 1'b1;
        Addr  = ADDR_SIZE'(OPA_ADDR);
        Wr_D  = data_reg;
      end
      ST_OPB_WR: begin
        Wr_En   = 1'b1;
        Addr    = ADDR_SIZE'(OPB_ADDR);
        Wr_D    = data_reg;
        Gate_En = 1'b1;
      end
      ST_FUN_WAIT: Gate_En = !alu_op_reg;
      ST_ALU_EXEC: begin
        ALU_En  = 1'b1;
        FUN     = fun_reg;
        Gate_En = 1'b1;
      end
      default: ;
    endcase
  end

  assign Busy       = (state_reg != ST_IDLE);
  assign Frame_Err  = err_reg;
  assign CLK_DIV_EN = 1'b1;
  assign load_rd    = (state_reg == ST_RD_REQ) && Rd_D_Valid;
  assign load_alu   = (state_reg == ST_ALU_EXEC) && OUT_Valid;
  assign tx_active  = (state_reg == ST_TX);

  sys_ctrl_tx_ser #(
    .D_WIDTH   (D_WIDTH),
    .RES_BYTES (RES_BYTES)
  ) u_tx_ser (
    .CLK       (CLK),
    .RST       (RST),
    .load_rd   (load_rd),
    .load_alu  (load_alu),
    .rd_data   (Rd_D),
    .alu_data  (ALU_OUT),
    .tx_active (tx_active),
    .FIFO_FULL (FIFO_FULL),
    .WR_INC    (WR_INC),
    .WR_DATA   (WR_DATA),
    .tx_done   (tx_done)
  );

endmodule

// File: tb/tb_sys_ctrl_v2.sv
// Directed bench for sys_ctrl_v2 with TIMEOUT=8.
// A negedge monitor logs register writes, FIFO pushes and error pulses for the checks.
module tb_sys_ctrl_v2;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  Sync_Frame;
  logic        enable_pulse;
  logic [7:0]  Rd_D;
  logic        Rd_D_Valid;
  logic        Rd_En, Wr_En;
  logic [3:0]  Addr;
  logic [7:0]  Wr_D;
  logic [15:0] ALU_OUT;
  logic        OUT_Valid;
  logic        ALU_En;
  logic [3:0]  FUN;
  logic        FIFO_FULL;
  logic        WR_INC;
  logic [7:0]  WR_DATA;
  logic        Gate_En, CLK_DIV_EN, Busy, Frame_Err;

  sys_ctrl_v2 #(
    .D_WIDTH(8), .ADDR_SIZE(4), .RES_BYTES(2), .OPA_ADDR(0), .OPB_ADDR(1),
    .TIMEOUT(8), .TO_W(4)
  ) dut (
    .CLK(CLK), .RST(RST), .Sync_Frame(Sync_Frame), .enable_pulse(enable_pulse),
    .Rd_D(Rd_D), .Rd_D_Valid(Rd_D_Valid), .Rd_En(Rd_En), .Wr_En(Wr_En),
    .Addr(Addr), .Wr_D(Wr_D), .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
    .ALU_En(ALU_En), .FUN(FUN), .FIFO_FULL(FIFO_FULL), .WR_INC(WR_INC),
    .WR_DATA(WR_DATA), .Gate_En(Gate_En), .CLK_DIV_EN(CLK_DIV_EN),
    .Busy(Busy), .Frame_Err(Frame_Err)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] wr_q[$];
  logic [7:0]  push_q[$];
  int          err_cnt = 0;
  int          rd_en_cnt = 0;
  int          alu_cnt = 0;
  logic [3:0]  last_fun = 4'h0;
  int          wr0, p0, e0, r0, a0;

  always @(negedge CLK) begin
    if (Wr_En)     wr_q.push_back({Addr, Wr_D});
    if (WR_INC)    push_q.push_back(WR_DATA);
    if (Frame_Err) err_cnt++;
    if (Rd_En)     rd_en_cnt++;
    if (ALU_En) begin
      alu_cnt++;
      last_fun = FUN;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    Sync_Frame   = b;
    enable_pulse = 1'b1;
    tick();
    enable_pulse = 1'b0;
    tick();
  endtask

  task automatic snap();
    wr0 = wr_q.size();
    p0  = push_q.size();
    e0  = err_cnt;
    r0  = rd_en_cnt;
    a0  = alu_cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; Sync_Frame = '0; enable_pulse = 1'b0; Rd_D = '0; Rd_D_Valid = 1'b0;
    ALU_OUT = '0; OUT_Valid = 1'b0; FIFO_FULL = 1'b0;
    tick(); tick();
    @(negedge CLK);
    check("rst_busy", Busy, 0);
    check("rst_wr_en", Wr_En, 0);
    check("rst_rd_en", Rd_En, 0);
    check("rst_alu_en", ALU_En, 0);
    check("rst_wr_inc", WR_INC, 0);
    check("rst_frame_err", Frame_Err, 0);
    check("rst_gate_en", Gate_En, 0);
    check("rst_addr", Addr, 0);
    check("rst_clk_div_en", CLK_DIV_EN, 1);
    tick();
    RST = 1'b1;
    tick();

    // write AA,05,3C
    snap();
    send(8'hAA); send(8'h05); send(8'h3C); tick(); tick();
    check("wr_count", wr_q.size() - wr0, 1);
    check("wr_addr_data", wr_q[wr0], {4'h5, 8'h3C});
    check("wr_no_push", push_q.size() - p0, 0);
    check("wr_no_err", err_cnt - e0, 0);
    @(negedge CLK);
    check("wr_busy_after", Busy, 0);
    tick();
    $display("step write: %0d writes", wr_q.size() - wr0);

    // read BB,07 with valid on the third Rd_En cycle
    snap();
    send(8'hBB); send(8'h07);
    tick();
    Rd_D = 8'h5A; Rd_D_Valid = 1'b1;
    tick();
    Rd_D_Valid = 1'b0;
    tick(); tick();
    check("rd_en_cycles", rd_en_cnt - r0, 3);
    check("rd_push_count", push_q.size() - p0, 1);
    check("rd_push_data", push_q[p0], 8'h5A);
    check("rd_no_err", err_cnt - e0, 0);
    $display("step read: %0d pushes", push_q.size() - p0);

    // ALU with operands CC,12,34,01 -> BEEF
    snap();
    send(8'hCC); send(8'h12); send(8'h34); send(8'h01);
    ALU_OUT = 16'hBEEF; OUT_Valid = 1'b1;
    tick();
    OUT_Valid = 1'b0;
    tick(); tick(); tick();
    check("alu_wr_count", wr_q.size() - wr0, 2);
    check("alu_opa_write", wr_q[wr0], {4'h0, 8'h12});
    check("alu_opb_write", wr_q[wr0+1], {4'h1, 8'h34});
    check("alu_en_cycles", alu_cnt - a0, 2);
    check("alu_fun", last_fun, 4'h1);
    check("alu_push_count", push_q.size() - p0, 2);
    check("alu_push_lsb", push_q[p0], 8'hEF);
    check("alu_push_msb", push_q[p0+1], 8'hBE);
    check("alu_no_err", err_cnt - e0, 0);
    $display("step alu: %0d pushes", push_q.size() - p0);

    // backpressure: FIFO_FULL for 5 cycles after the first push
    snap();
    send(8'hCC); send(8'h12); send(8'h34); send(8'h01);
    ALU_OUT = 16'hBEEF; OUT_Valid = 1'b1;
    tick();
    OUT_Valid = 1'b0;
    tick();
    FIFO_FULL = 1'b1;
    @(negedge CLK);
    check("bp_stall_wr_inc", WR_INC, 0);
    check("bp_stall_data", WR_DATA, 8'hBE);
    check("bp_stall_busy", Busy, 1);
    repeat (5) @(posedge CLK);
    #1;
    FIFO_FULL = 1'b0;
    tick(); tick();
    check("bp_push_count", push_q.size() - p0, 2);
    check("bp_push_lsb", push_q[p0], 8'hEF);
    check("bp_push_msb", push_q[p0+1], 8'hBE);
    check("bp_no_err", err_cnt - e0, 0);
    $display("step backpressure: %0d pushes", push_q.size() - p0);

    // timeout: AA then silence
    snap();
    Sync_Frame = 8'hAA; enable_pulse = 1'b1;
    tick();
    enable_pulse = 1'b0;
    repeat (7) tick();
    @(negedge CLK);
    check("to_err_early", Frame_Err, 0);
    check("to_busy_early", Busy, 1);
    tick();
    @(negedge CLK);
    check("to_err_pulse", Frame_Err, 1);
    check("to_idle", Busy, 0);
    tick();
    @(negedge CLK);
    check("to_err_one_cycle", Frame_Err, 0);
    tick();
    check("to_no_write", wr_q.size() - wr0, 0);
    check("to_err_count", err_cnt - e0, 1);
    check("to_no_push", push_q.size() - p0, 0);
    $display("step timeout: %0d errors", err_cnt - e0);

    // timeout race: frame arrives on the eighth cycle
    snap();
    Sync_Frame = 8'hAA; enable_pulse = 1'b1;
    tick();
    enable_pulse = 1'b0;
    repeat (7) tick();
    Sync_Frame = 8'h05; enable_pulse = 1'b1;
    tick();
    enable_pulse = 1'b0;
    tick();
    send(8'h3C); tick(); tick();
    check("race_no_err", err_cnt - e0, 0);
    check("race_wr_count", wr_q.size() - wr0, 1);
    check("race_wr_addr_data", wr_q[wr0], {4'h5, 8'h3C});
    $display("step timeout race: %0d writes", wr_q.size() - wr0);

    // unknown command
    snap();
    Sync_Frame = 8'h77; enable_pulse = 1'b1;
    tick();
    enable_pulse = 1'b0;
    @(negedge CLK);
    check("unk_err", Frame_Err, 1);
    check("unk_idle", Busy, 0);
    tick(); tick();
    check("unk_err_count", err_cnt - e0, 1);
    $display("step unknown cmd: %0d errors", err_cnt - e0);

    // overrun during ALU_EXEC on a DD command
    snap();
    send(8'hDD);
    @(negedge CLK);
    check("nop_gate_fun_wait", Gate_En, 1);
    tick();
    send(8'h03);
    Sync_Frame = 8'h55; enable_pulse = 1'b1;
    tick();
    enable_pulse = 1'b0;
    @(negedge CLK);
    check("ovr_err", Frame_Err, 1);
    check("ovr_busy", Busy, 1);
    check("ovr_alu_en", ALU_En, 1);
    tick();
    ALU_OUT = 16'h1234; OUT_Valid = 1'b1;
    tick();
    OUT_Valid = 1'b0;
    tick(); tick(); tick();
    check("ovr_push_count", push_q.size() - p0, 2);
    check("ovr_push_lsb", push_q[p0], 8'h34);
    check("ovr_push_msb", push_q[p0+1], 8'h12);
    check("ovr_err_count", err_cnt - e0, 1);
    check("ovr_fun", last_fun, 4'h3);
    check("ovr_no_write", wr_q.size() - wr0, 0);
    $display("step overrun: %0d pushes", push_q.size() - p0);

    // reset mid-TX after the first byte
    snap();
    send(8'hDD); send(8'h05);
    ALU_OUT = 16'hA5C3; OUT_Valid = 1'b1;
    tick();
    OUT_Valid = 1'b0;
    tick();
    FIFO_FULL = 1'b1;
    @(negedge CLK);
    check("rtx_stalled", WR_INC, 0);
    tick();
    RST = 1'b0;
    FIFO_FULL = 1'b0;
    @(negedge CLK);
    check("rtx_wr_inc", WR_INC, 0);
    check("rtx_busy", Busy, 0);
    check("rtx_wr_data", WR_DATA, 0);
    check("rtx_gate_en", Gate_En, 0);
    check("rtx_alu_en", ALU_En, 0);
    check("rtx_clk_div_en", CLK_DIV_EN, 1);
    tick(); tick();
    RST = 1'b1;
    tick(); tick();
    check("rtx_push_count", push_q.size() - p0, 1);
    check("rtx_first_byte", push_q[p0], 8'hC3);
    check("rtx_no_err", err_cnt - e0, 0);
    @(negedge CLK);
    check("rtx_idle_after", Busy, 0);
    $display("step reset mid-tx: %0d pushes", push_q.size() - p0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sys_ctrl_v2.md
Name: sys_ctrl_v2

Overview:
Second-generation system controller for the UART-command datapath. It parses byte frames from the data synchroniser into register-file writes and reads and ALU operations, with or without operands. Results are streamed into the async TX FIFO. Over the first generation it adds:
- parametrised frame, address and result widths
- multi-byte result serialisation
- configurable operand register addresses
- a per-frame inactivity timeout
- error reporting for unknown commands and frame overruns

Parameters:
D_WIDTH, 8, frame, register and FIFO data width
ADDR_SIZE, 4, register-file address width (must be <= D_WIDTH)
RES_BYTES, 2, ALU result width in frames; ALU_O_W = D_WIDTH*RES_BYTES
OPA_ADDR, 0, register address for operand A
OPB_ADDR, 1, register address for operand B
TIMEOUT, 1023, max idle cycles inside a frame; 0 disables the timeout
TO_W, 10, timeout counter width (>= clog2(TIMEOUT+1))

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
Sync_Frame  in  D_WIDTH  synchronised RX frame
enable_pulse  in  1  one-cycle frame-valid strobe
Rd_D  in  D_WIDTH  register-file read data
Rd_D_Valid  in  1  read data valid
Rd_En  out  1  register read strobe
Wr_En  out  1  register write strobe
Addr  out  ADDR_SIZE  register address
Wr_D  out  D_WIDTH  register write data
ALU_OUT  in  ALU_O_W  ALU result
OUT_Valid  in  1  ALU result valid
ALU_En  out  1  ALU enable
FUN  out  4  ALU function
FIFO_FULL  in  1  TX FIFO full
WR_INC  out  1  FIFO push
WR_DATA  out  D_WIDTH  FIFO push data
Gate_En  out  1  ALU clock-gate enable
CLK_DIV_EN  out  1  clock-divider enable, constant 1
Busy  out  1  high whenever state != IDLE
Frame_Err  out  1  one-cycle error pulse

Behaviour:
- Reset: async to IDLE. All outputs 0 except CLK_DIV_EN=1. Stored frames, result register, byte index and timeout counter all cleared. Reset mid-frame aborts silently with no FIFO push.
- Commands, accepted in IDLE on enable_pulse:
  - 0xAA: write
  - 0xBB: read
  - 0xCC: ALU with operands
  - 0xDD: ALU without operands
  - Any other byte: Frame_Err pulses next cycle, state stays IDLE.
- Command flows (each wait state advances on enable_pulse and captures Sync_Frame into a register):
  - WR: WR_ADDR -> WR_DATA -> WR_EXEC. WR_EXEC lasts 1 cycle with Wr_En=1, Addr=addr[ADDR_SIZE-1:0], Wr_D=stored data, then returns to IDLE.
  - RD: RD_ADDR -> RD_REQ. In RD_REQ, Rd_En=1 and Addr=stored addr until Rd_D_Valid. Rd_D is latched into result[D_WIDTH-1:0] with zero-extension and the block goes to TX with byte count 1.
  - ALU (0xCC): OPA_WAIT -> OPA_WR (1 cycle, Wr_En, Addr=OPA_ADDR) -> OPB_WAIT -> OPB_WR (1 cycle, Wr_En, Addr=OPB_ADDR, Gate_En=1) -> FUN_WAIT -> ALU_EXEC.
  - ALU (0xDD): FUN_WAIT -> ALU_EXEC.
- FUN_WAIT and ALU_EXEC:
  - Gate_En=1 in FUN_WAIT when the command is 0xDD, and always in ALU_EXEC.
  - ALU_EXEC holds ALU_En=1 and FUN=stored fun[3:0] (registered, never live Sync_Frame) until OUT_Valid.
  - On OUT_Valid, ALU_OUT is latched and the block goes to TX with byte count RES_BYTES.
- Outputs are decoded from state and stored registers. The exception is WR_INC, which depends combinationally on FIFO_FULL.
- TX state:
  - WR_INC = !FIFO_FULL; WR_DATA = result byte[idx], sent LSB byte first.
  - idx increments on each push. After the last push the block returns to IDLE and idx returns to 0.
  - FIFO_FULL stalls TX indefinitely. The timeout does not apply in TX.
- Timeout:
  - The counter clears on every state change and on every enable_pulse.
  - It increments in all wait-for-pulse states and in RD_REQ/ALU_EXEC.
  - When the count reaches TIMEOUT: go to IDLE, pulse Frame_Err, push nothing to the FIFO.
  - If enable_pulse arrives in the same cycle the count reaches TIMEOUT, the pulse wins.
- Overrun: enable_pulse arriving in any non-wait state (a *_EXEC, *_WR, RD_REQ or TX state) drops the frame and pulses Frame_Err. The state is unaffected.
- Frame_Err is registered, a 1-cycle pulse. It never coincides with WR_INC for the same frame.

Decomposition:
- Shared package sys_ctrl_pkg holds the command codes (CMD_WR=8'hAA, CMD_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD) and the state encoding constants.
- One sub-module, sys_ctrl_tx_ser, is natural. It holds the result register, the byte index and the push logic, parametrised by D_WIDTH/RES_BYTES.

Test Plan:
- Write: frames AA,05,3C -> exactly one Wr_En cycle with Addr=5, Wr_D=0x3C; no WR_INC; Busy low after.
- Read: frames BB,07; Rd_D_Valid after 3 cycles with Rd_D=0x5A -> Rd_En high for those cycles; one WR_INC with WR_DATA=0x5A.
- ALU with operands: frames CC,12,34,01; ALU_OUT=0xBEEF -> writes 0x12@0 then 0x34@1; ALU_En with FUN=1; pushes 0xEF then 0xBE.
- Backpressure: same as the ALU test with FIFO_FULL high for 5 cycles after the first push -> second push held, then exactly one 0xBE push; no Frame_Err.
- Timeout: TIMEOUT=8; send AA then nothing -> Frame_Err 8 cycles after entering WR_ADDR; IDLE; no Wr_En. Repeat with enable_pulse on the 8th cycle -> continues normally.
- Errors/reset: command 0x77 -> Frame_Err, stays IDLE. An extra pulse during ALU_EXEC -> Frame_Err, result still delivered. RST low mid-TX -> no further pushes, all outputs at reset values.
